// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP NAPOT region writer: FSM states,
// response codes, CSR base addresses and the pmpcfg byte layout.
package pmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WR_ADDR,
    ST_WR_CFG,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_SIZE    = 2'b01,
    ERR_LOCKED  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [1:0]  A_NAPOT      = 2'b11;

  // pmpcfg byte: {L, reserved[1:0], A[1:0], X, W, R}
  function automatic logic [7:0] cfg_byte(input logic lock, input logic [2:0] perm);
    return {lock, 2'b00, A_NAPOT, perm};
  endfunction

endpackage

// File: rtl/pmp_napot_writer_napot_enc.sv
// NAPOT encoder: turns a byte base and log2 size into a pmpaddr value and
// flags sizes outside 8 B..32 GiB or bases not aligned to the region size.
module napot_enc
  import pmp_pkg::*;
(
  input  logic [31:0] i_base,
  input  logic [5:0]  i_size_log2,
  output logic [31:0] o_encoded,
  output logic        o_misaligned
);

  logic [34:0] w_size_mask;
  logic        w_size_ok;

  // For k=35 the shift wraps to zero, so the mask correctly becomes all ones.
  always_comb begin
    w_size_mask  = (35'd1 << i_size_log2) - 35'd1;
    w_size_ok    = (i_size_log2 >= 6'd3) && (i_size_log2 <= 6'd35);
    o_misaligned = !w_size_ok || (|(w_size_mask[31:0] & i_base));
    o_encoded    = w_size_ok ? (i_base | w_size_mask[34:3]) : i_base;
  end

endmodule

// File: rtl/pmp_napot_writer.sv
// Programs one PMP entry as a NAPOT region: validates the request, writes
// pmpaddrN then the matching pmpcfg byte over a CSR port, and reports status.
module pmp_napot_writer
  import pmp_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_entry,
  input  logic [31:0] i_req_base,
  input  logic [5:0]  i_req_size_log2,
  input  logic [2:0]  i_req_perm,
  input  logic        i_req_lock,
  input  logic [15:0] i_entry_locked,
  output logic        o_csr_valid,
  input  logic        i_csr_ack,
  output logic [11:0] o_csr_addr,
  output logic [31:0] o_csr_wdata,
  output logic [3:0]  o_csr_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [1:0]  o_rsp_err,
  output logic [31:0] o_rsp_addr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic          r_req_ready;
  logic [3:0]    r_entry;
  logic [31:0]   r_base;
  logic [5:0]    r_size_log2;
  logic [2:0]    r_perm;
  logic          r_lock;
  logic          r_csr_valid;
  logic [11:0]   r_csr_addr;
  logic [31:0]   r_csr_wdata;
  logic [3:0]    r_csr_wstrb;
  logic          r_rsp_valid;
  logic [1:0]    r_rsp_err;
  logic [31:0]   r_rsp_addr;
  logic [TW-1:0] r_tmo;

  logic [31:0]   w_enc;
  logic          w_misaligned;

  napot_enc u_enc (
    .i_base       (r_base),
    .i_size_log2  (r_size_log2),
    .o_encoded    (w_enc),
    .o_misaligned (w_misaligned)
  );

  // r_tmo counts unacked csr_valid cycles; an ack always wins over expiry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_entry     <= '0;
      r_base      <= '0;
      r_size_log2 <= '0;
      r_perm      <= '0;
      r_lock      <= 1'b0;
      r_csr_valid <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
      r_csr_wstrb <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= ERR_OK;
      r_rsp_addr  <= '0;
      r_tmo       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_entry     <= i_req_entry;
            r_base      <= i_req_base;
            r_size_log2 <= i_req_size_log2;
            r_perm      <= i_req_perm;
            r_lock      <= i_req_lock;
            r_state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_rsp_addr <= w_enc;
          if (w_misaligned) begin
            r_rsp_err   <= ERR_SIZE;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (i_entry_locked[r_entry]) begin
            r_rsp_err   <= ERR_LOCKED;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_csr_valid <= 1'b1;
            r_csr_addr  <= PMPADDR_BASE + {8'd0, r_entry};
            r_csr_wdata <= w_enc;
            r_csr_wstrb <= 4'hF;
            r_tmo       <= '0;
            r_state     <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (i_csr_ack) begin
            r_csr_addr  <= PMPCFG_BASE + {10'd0, r_entry[3:2]};
            r_csr_wstrb <= 4'b0001 << r_entry[1:0];
            r_csr_wdata <= {24'd0, cfg_byte(r_lock, r_perm)} << {r_entry[1:0], 3'b000};
            r_tmo       <= '0;
            r_state     <= ST_WR_CFG;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_csr_valid <= 1'b0;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_WR_CFG: begin
          if (i_csr_ack) begin
            r_csr_valid <= 1'b0;
            r_rsp_err   <= ERR_OK;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_csr_valid <= 1'b0;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_csr_valid = r_csr_valid;
  assign o_csr_addr  = r_csr_addr;
  assign o_csr_wdata = r_csr_wdata;
  assign o_csr_wstrb = r_csr_wstrb;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_addr  = r_rsp_addr;

endmodule

// File: tb/tb_pmp_napot_writer.sv
// Bench for pmp_napot_writer: directed requests against a queue-based model
// of expected CSR writes and responses, checked every cycle by a monitor.
module tb_pmp_napot_writer;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [3:0]  reqEntry = '0;
  logic [31:0] reqBase = '0;
  logic [5:0]  reqSize = '0;
  logic [2:0]  reqPerm = '0;
  logic        reqLock = 1'b0;
  logic [15:0] lockedMask = '0;
  logic        csrValid;
  logic        csrAck = 1'b0;
  logic [11:0] csrAddr;
  logic [31:0] csrWdata;
  logic [3:0]  csrWstrb;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [1:0]  rspErr;
  logic [31:0] rspAddr;

  always #5 clk = ~clk;

  pmp_napot_writer #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_entry(reqEntry), .i_req_base(reqBase), .i_req_size_log2(reqSize),
    .i_req_perm(reqPerm), .i_req_lock(reqLock), .i_entry_locked(lockedMask),
    .o_csr_valid(csrValid), .i_csr_ack(csrAck), .o_csr_addr(csrAddr),
    .o_csr_wdata(csrWdata), .o_csr_wstrb(csrWstrb),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_err(rspErr), .o_rsp_addr(rspAddr)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          accepted;
  } wr_t;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] addr;
    bit          checkAddr;
  } rsp_t;

  wr_t  expWr[$];
  rsp_t expRsp[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   cycleCount = 0;
  int   ackAddr = 0;
  int   ackCfg = 0;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Plain arithmetic view of NAPOT: region of 2^k bytes, pmpaddr holds base>>2
  // with (k-3) trailing ones, expressed here on the byte address directly.
  function automatic void modelEncode(input logic [31:0] base, input int k,
                                      output logic [31:0] enc, output bit bad);
    longint unsigned size;
    longint unsigned b;
    b = base;
    if (k < 3 || k > 35) begin
      enc = base;
      bad = 1'b1;
    end else begin
      size = 64'd1 << k;
      bad  = (b % size) != 0;
      enc  = (k == 35) ? 32'hFFFF_FFFF : (base | 32'((size / 8) - 1));
    end
  endfunction

  task automatic modelRequest(input int entry, input logic [31:0] base, input int k,
                              input int perm, input int lock, input int ackA, input int ackC);
    logic [31:0] enc;
    bit          bad;
    bit          okA;
    bit          okC;
    int          lane;
    logic [7:0]  cfg;
    wr_t         w;
    rsp_t        r;
    modelEncode(base, k, enc, bad);
    okA  = ackA <= TIMEOUT;
    okC  = ackC <= TIMEOUT;
    lane = entry % 4;
    r.addr = enc;
    r.checkAddr = 1'b1;
    if (bad) begin
      r.err = 2'b01;
      r.checkAddr = (k >= 3 && k <= 35);
      expRsp.push_back(r);
    end else if (lockedMask[entry]) begin
      r.err = 2'b10;
      expRsp.push_back(r);
    end else begin
      w.addr = 12'(12'h3B0 + entry);
      w.data = enc;
      w.strb = 4'hF;
      w.accepted = okA;
      expWr.push_back(w);
      if (!okA) begin
        r.err = 2'b11;
      end else begin
        cfg = {1'(lock), 2'b00, 2'b11, 3'(perm)};
        w.addr = 12'(12'h3A0 + entry / 4);
        w.data = 32'(cfg) << (8 * lane);
        w.strb = 4'(1 << lane);
        w.accepted = okC;
        expWr.push_back(w);
        r.err = okC ? 2'b00 : 2'b11;
      end
      expRsp.push_back(r);
    end
  endtask

  // CSR target: acks the current write on its Nth valid cycle (0 = tied high).
  int ackCyc = 0;
  int ackLim = 0;
  bit ackPrevHs = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ackCyc = 0;
      ackPrevHs = 1'b0;
      csrAck = 1'b0;
    end else begin
      if (ackPrevHs) ackCyc = 0;
      ackLim = (csrAddr[7:4] == 4'hB) ? ackAddr : ackCfg;
      if (csrValid) begin
        ackCyc++;
        csrAck = (ackLim == 0) || (ackCyc >= ackLim);
      end else begin
        ackCyc = 0;
        csrAck = (ackAddr == 0);
      end
      ackPrevHs = csrValid && csrAck;
    end
  end

  // Monitor: every presented CSR write and response must match the model queues.
  bit prevCsrValid = 1'b0;
  bit prevCsrAck = 1'b0;
  int runLen = 0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prevCsrValid = 1'b0;
      prevCsrAck = 1'b0;
      runLen = 0;
    end else begin
      if (csrValid || rspValid) checkOutput("req_ready_busy", reqReady, 1'b0);
      if (csrValid) begin
        if (expWr.size() == 0) begin
          reportTimeout("unexpected_csr_valid");
        end else begin
          checkOutput("csr_addr", csrAddr, expWr[0].addr);
          checkOutput("csr_wdata", csrWdata, expWr[0].data);
          checkOutput("csr_wstrb", csrWstrb, expWr[0].strb);
          if (csrAck) begin
            checkOutput("csr_accept_expected", 1'b1, expWr[0].accepted);
            checkOutput("ack_within_timeout", runLen < TIMEOUT, 1'b1);
            void'(expWr.pop_front());
            runLen = 0;
          end else begin
            runLen++;
          end
        end
      end else if (prevCsrValid && !prevCsrAck) begin
        checkOutput("timeout_cycles", runLen, TIMEOUT);
        if (expWr.size() == 0) begin
          reportTimeout("unexpected_csr_drop");
        end else begin
          checkOutput("csr_drop_expected", 1'b0, expWr[0].accepted);
          void'(expWr.pop_front());
        end
        runLen = 0;
      end
      if (rspValid) begin
        if (expRsp.size() == 0) begin
          reportTimeout("unexpected_rsp_valid");
        end else begin
          checkOutput("rsp_err", rspErr, expRsp[0].err);
          if (expRsp[0].checkAddr) checkOutput("rsp_addr", rspAddr, expRsp[0].addr);
          if (rspReady) void'(expRsp.pop_front());
        end
      end
      prevCsrValid = csrValid;
      prevCsrAck = csrAck;
    end
  end

  task automatic driveRequest(input int entry, input logic [31:0] base, input int k,
                              input int perm, input int lock, output int t0);
    bit ok;
    @(negedge clk);
    reqEntry = 4'(entry);
    reqBase  = base;
    reqSize  = 6'(k);
    reqPerm  = 3'(perm);
    reqLock  = 1'(lock);
    reqValid = 1'b1;
    ok = 1'b0;
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (reqReady) begin
        ok = 1'b1;
        t0 = cycleCount;
        break;
      end
      @(negedge clk);
    end
    if (!ok) reportTimeout("req_ready_wait");
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic applyStimulus(input int entry, input logic [31:0] base, input int k,
                               input int perm, input int lock, input int ackA,
                               input int ackC, input int hold, output int latency);
    int t0;
    bit seen;
    ackAddr = ackA;
    ackCfg = ackC;
    modelRequest(entry, base, k, perm, lock, ackA, ackC);
    driveRequest(entry, base, k, perm, lock, t0);
    seen = 1'b0;
    latency = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rspValid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      reportTimeout("rsp_valid_wait");
    end else begin
      latency = cycleCount - t0;
      repeat (hold) begin
        checkOutput("req_ready_low_in_resp", reqReady, 1'b0);
        @(negedge clk);
      end
      rspReady = 1'b1;
      @(posedge clk);
      #1 rspReady = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int t0;
    bit seen;
    logic [31:0] enc;
    bit bad;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", reqReady, 1'b0);
    checkOutput("reset_csr_valid", csrValid, 1'b0);
    checkOutput("reset_rsp_valid", rspValid, 1'b0);
    checkOutput("reset_rsp_err", rspErr, 2'b00);
    checkOutput("reset_rsp_addr", rspAddr, 32'h0);
    checkOutput("reset_csr_addr", csrAddr, 12'h0);
    checkOutput("reset_csr_wdata", csrWdata, 32'h0);
    checkOutput("reset_csr_wstrb", csrWstrb, 4'h0);
    rst = 1'b0;

    $display("[TB] Pinning the model against hand-computed vectors");
    modelRequest(5, 32'h8000_0000, 12, 3'b011, 0, 0, 0);
    checkOutput("pin_wr1_addr", expWr[0].addr, 12'h3B5);
    checkOutput("pin_wr1_data", expWr[0].data, 32'h8000_01FF);
    checkOutput("pin_wr1_strb", expWr[0].strb, 4'hF);
    checkOutput("pin_wr2_addr", expWr[1].addr, 12'h3A1);
    checkOutput("pin_wr2_data", expWr[1].data, 32'h0000_1B00);
    checkOutput("pin_wr2_strb", expWr[1].strb, 4'b0010);
    checkOutput("pin_rsp_err", expRsp[0].err, 2'b00);
    expWr.delete();
    expRsp.delete();
    modelEncode(32'h8000_0100, 12, enc, bad);
    checkOutput("pin_misaligned_enc", enc, 32'h8000_01FF);
    checkOutput("pin_misaligned_bad", bad, 1'b1);
    modelEncode(32'h0, 35, enc, bad);
    checkOutput("pin_k35_enc", enc, 32'hFFFF_FFFF);
    modelEncode(32'h0, 34, enc, bad);
    checkOutput("pin_k34_enc", enc, 32'h7FFF_FFFF);
    modelRequest(15, 32'h4000_0000, 30, 3'b111, 1, 0, 0);
    checkOutput("pin_e15_wr1_data", expWr[0].data, 32'h47FF_FFFF);
    checkOutput("pin_e15_wr2_addr", expWr[1].addr, 12'h3A3);
    checkOutput("pin_e15_wr2_data", expWr[1].data, 32'h9F00_0000);
    checkOutput("pin_e15_wr2_strb", expWr[1].strb, 4'b1000);
    expWr.delete();
    expRsp.delete();

    $display("[TB] Basic program with ack tied high");
    applyStimulus(5, 32'h8000_0000, 12, 3'b011, 0, 0, 0, 0, lat);
    checkOutput("min_latency_rsp_valid", lat, 4);
    applyStimulus(15, 32'h4000_0000, 30, 3'b111, 1, 1, 3, 0, lat);

    $display("[TB] Size and alignment errors");
    applyStimulus(1, 32'h8000_0100, 12, 3'b001, 0, 1, 1, 0, lat);
    applyStimulus(0, 32'h8000_0000, 2, 3'b001, 0, 1, 1, 0, lat);
    applyStimulus(0, 32'h0000_0100, 35, 3'b001, 0, 1, 1, 0, lat);
    applyStimulus(0, 32'h0000_0000, 36, 3'b001, 0, 1, 1, 0, lat);

    $display("[TB] Locked entries");
    lockedMask = 16'h0008;
    applyStimulus(3, 32'h0000_1000, 12, 3'b011, 0, 1, 1, 0, lat);
    applyStimulus(3, 32'h0000_1100, 12, 3'b011, 0, 1, 1, 0, lat);
    applyStimulus(4, 32'h0000_1000, 12, 3'b101, 0, 1, 1, 0, lat);
    lockedMask = 16'h0000;

    $display("[TB] CSR ack timeout handling");
    applyStimulus(6, 32'h2000_0000, 16, 3'b011, 0, NEVER, 1, 0, lat);
    applyStimulus(7, 32'h2000_0000, 16, 3'b011, 0, TIMEOUT, TIMEOUT, 0, lat);
    applyStimulus(9, 32'h0001_0000, 8, 3'b110, 0, 2, NEVER, 0, lat);

    $display("[TB] Whole address space and response backpressure");
    applyStimulus(0, 32'h0000_0000, 35, 3'b111, 0, 0, 0, 5, lat);
    applyStimulus(8, 32'h0000_0000, 34, 3'b001, 0, 0, 0, 2, lat);

    $display("[TB] Reset during the pmpcfg write");
    ackAddr = 1;
    ackCfg = NEVER;
    modelRequest(2, 32'h0000_4000, 14, 3'b001, 0, 1, NEVER);
    driveRequest(2, 32'h0000_4000, 14, 3'b001, 0, t0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (csrValid && csrAddr == 12'h3A0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("wr_cfg_wait");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_csr_valid", csrValid, 1'b0);
    checkOutput("midreset_rsp_valid", rspValid, 1'b0);
    checkOutput("midreset_req_ready", reqReady, 1'b0);
    checkOutput("midreset_csr_wstrb", csrWstrb, 4'h0);
    expWr.delete();
    expRsp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reqReady) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("req_ready_after_reset");
    checkOutput("rsp_valid_after_reset", rspValid, 1'b0);
    applyStimulus(2, 32'h0000_4000, 14, 3'b001, 0, 0, 0, 0, lat);
    checkOutput("latency_after_reset", lat, 4);

    repeat (3) @(negedge clk);
    checkOutput("expected_writes_drained", expWr.size(), 0);
    checkOutput("expected_rsps_drained", expRsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
